display_refresh_scheduler: RTL and testbench

DISPLAY_REFRESH_SCHEDULER -- requirements
Module: display_refresh_scheduler

---
 rtl/display_refresh_scheduler_pkg.sv | 23 ++
 rtl/display_refresh_scheduler_if.sv | 10 +
 rtl/display_refresh_scheduler_slot_timer.sv | 30 +++
 rtl/display_refresh_scheduler.sv | 101 ++++++++++
 tb/tb_display_refresh_scheduler.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/display_refresh_scheduler_pkg.sv
// Shared definitions for the display refresh scheduler: slot state encoding,
// default timing parameters and small state helpers.
package display_pkg;

    localparam int DEFAULT_PRESCALE     = 50000;
    localparam int DEFAULT_BLANK_CYCLES = 500;

    // Slot states; bit 1 doubles as the digit select, bit 0 marks a blanking gap.
    localparam logic [1:0] ST_ON0  = 2'd0;
    localparam logic [1:0] ST_GAP0 = 2'd1;
    localparam logic [1:0] ST_ON1  = 2'd2;
    localparam logic [1:0] ST_GAP1 = 2'd3;

    // Fixed cyclic order ON0 -> GAP0 -> ON1 -> GAP1 -> ON0 is a plain 2-bit increment.
    function automatic logic [1:0] next_slot(input logic [1:0] s);
        return s + 2'd1;
    endfunction

    function automatic logic is_gap(input logic [1:0] s);
        return s[0];
    endfunction

endpackage

// File: rtl/display_refresh_scheduler_if.sv
// Requester-side interface: byte handshake plus the display enable.
interface display_refresh_scheduler_if;
    logic       displayOn;
    logic       valueValid;
    logic [7:0] valueIn;
    logic       valueReady;

    modport master (output displayOn, output valueValid, output valueIn, input valueReady);
    modport slave  (input displayOn, input valueValid, input valueIn, output valueReady);
endinterface

// File: rtl/display_refresh_scheduler_slot_timer.sv
// Loadable saturating down-counter; done is high while the count sits at zero.
// The owner asserts load on reset, so no separate reset input is needed.
module slot_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Reload wins; otherwise count down and hold at zero (no wrap).
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == '0);
endmodule

// File: rtl/display_refresh_scheduler.sv
// Two-digit display refresh scheduler: sequences ON0/GAP0/ON1/GAP1 slots,
// buffers one requested byte and commits it only at the frame boundary.
module display_refresh_scheduler
    import display_pkg::*;
#(
    parameter int PRESCALE     = DEFAULT_PRESCALE,
    parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
    input  logic                         clk,
    input  logic                         reset,
    display_refresh_scheduler_if.slave   req,
    output logic                         counter,
    output logic [3:0]                   segment2,
    output logic [3:0]                   segment1,
    output logic                         blank,
    output logic                         frameTick
);
    localparam int SLOT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int CW       = (SLOT_MAX > 1) ? $clog2(SLOT_MAX) : 1;
    // A slot of N cycles loads N-1 and transitions on the cycle the count hits zero.
    localparam logic [CW-1:0] ON_LOAD  = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(BLANK_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic          slot_done, slot_load;
    logic [CW-1:0] slot_val;
    logic          blank_q, blank_d;
    logic          tick_q, tick_d;
    logic          ready_q, ready_d;
    logic          pend_full_q, pend_full_d;
    logic [7:0]    pend_q, pend_d;
    logic [7:0]    seg_q, seg_d;
    logic          frame_edge;

    slot_timer #(.W(CW)) u_slot_timer (
        .clk        (clk),
        .load_i     (slot_load),
        .load_val_i (slot_val),
        .done_o     (slot_done)
    );

    assign frame_edge = slot_done && (state_q == ST_GAP1);

    // Slot sequencing and timer reload; reset parks in GAP1 with a full blanking load.
    always_comb begin
        state_d = state_q;
        if (reset) begin
            state_d = ST_GAP1;
        end else if (slot_done) begin
            state_d = next_slot(state_q);
        end
        slot_load = reset || slot_done;
        slot_val  = is_gap(state_d) ? GAP_LOAD : ON_LOAD;
        blank_d   = is_gap(state_d) || !req.displayOn;
        tick_d    = !reset && frame_edge;
    end

    // One-deep buffer: commit at the GAP1->ON0 edge, otherwise accept when empty.
    // A commit needs a full buffer, which holds ready low, so the two never coincide.
    always_comb begin
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        seg_d       = seg_q;
        if (frame_edge && pend_full_q) begin
            seg_d       = pend_q;
            pend_full_d = 1'b0;
        end else if (req.valueValid && ready_q) begin
            pend_d      = req.valueIn;
            pend_full_d = 1'b1;
        end
        ready_d = !pend_full_d;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_GAP1;
            blank_q     <= 1'b1;
            tick_q      <= 1'b0;
            ready_q     <= 1'b1;
            pend_full_q <= 1'b0;
            pend_q      <= 8'h00;
            seg_q       <= 8'h00;
        end else begin
            state_q     <= state_d;
            blank_q     <= blank_d;
            tick_q      <= tick_d;
            ready_q     <= ready_d;
            pend_full_q <= pend_full_d;
            pend_q      <= pend_d;
            seg_q       <= seg_d;
        end
    end

    assign counter        = state_q[1];
    assign segment2       = seg_q[7:4];
    assign segment1       = seg_q[3:0];
    assign blank          = blank_q;
    assign frameTick      = tick_q;
    assign req.valueReady = ready_q;
endmodule

// File: tb/tb_display_refresh_scheduler.sv
// Directed bench for display_refresh_scheduler with PRESCALE=4, BLANK_CYCLES=2.
// A negedge monitor compares every cycle against a frame-position model and a
// scoreboard queue of accepted bytes; the initial block adds directed checks.
module tb_display_refresh_scheduler;
    localparam int P     = 4;
    localparam int B     = 2;
    localparam int FRAME = 2 * (P + B);

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       counter, blank, frameTick;
    logic [3:0] segment2, segment1;

    display_refresh_scheduler_if rif();

    display_refresh_scheduler #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (rif),
        .counter   (counter),
        .segment2  (segment2),
        .segment1  (segment1),
        .blank     (blank),
        .frameTick (frameTick)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    bit         started = 1'b0;
    logic       don_prev = 1'b1;
    logic [7:0] exp_q[$];
    logic [7:0] disp_exp = 8'h00;

    // cycle 0 is the first GAP1 cycle after a reset edge; position 0 is the ON0 tick cycle
    function automatic int pos_of(input int c);
        return (c + FRAME - B) % FRAME;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_pos(input int k);
        int n;
        n = 0;
        while (pos_of(cyc) != k && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_pos_bound", 8'(n < 30), 8'd1);
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        rif.valueValid = 1'b1;
        rif.valueIn    = b;
        @(negedge clk);
        while (!rif.valueReady && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", 8'(n < 40), 8'd1);
        @(posedge clk);
        #1;
        rif.valueValid = 1'b0;
    endtask

    // Per-cycle model check, then advance the model across the coming edge.
    always @(negedge clk) begin
        int p;
        p = pos_of(cyc);
        if (started) begin
            chk("frameTick", 8'(frameTick), 8'(p == 0));
            chk("counter", 8'(counter), 8'(p >= FRAME / 2));
            chk("blank", 8'(blank), 8'((p >= P && p < P + B) || p >= 2 * P + B || !don_prev));
            chk("valueReady", 8'(rif.valueReady), 8'(exp_q.size() == 0));
            chk("segments", {segment2, segment1}, disp_exp);
        end
        if (reset) begin
            cyc = 0;
            exp_q.delete();
            disp_exp = 8'h00;
            started  = 1'b1;
        end else begin
            cyc++;
            if (pos_of(cyc) == 0 && exp_q.size() != 0) begin
                disp_exp = exp_q.pop_front();
            end else if (exp_q.size() == 0 && rif.valueValid) begin
                exp_q.push_back(rif.valueIn);
            end
        end
        don_prev = rif.displayOn;
    end

    initial begin
        rif.displayOn  = 1'b1;
        rif.valueValid = 1'b0;
        rif.valueIn    = 8'h00;
        reset          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_counter", 8'(counter), 8'd1);
        chk("rst_blank", 8'(blank), 8'd1);
        chk("rst_tick", 8'(frameTick), 8'd0);
        chk("rst_segments", {segment2, segment1}, 8'h00);
        chk("rst_ready", 8'(rif.valueReady), 8'd1);
        reset = 1'b0;

        // idle frames: first tick exactly BLANK_CYCLES after release
        step(1);
        chk("idle_tick_c1", 8'(frameTick), 8'd0);
        step(1);
        chk("idle_tick_c2", 8'(frameTick), 8'd1);
        chk("idle_counter_c2", 8'(counter), 8'd0);
        chk("idle_blank_c2", 8'(blank), 8'd0);
        step(24);

        // single byte accepted mid-frame
        wait_pos(5);
        rif.valueValid = 1'b1;
        rif.valueIn    = 8'hA5;
        step(1);
        rif.valueValid = 1'b0;
        chk("a5_ready_low", 8'(rif.valueReady), 8'd0);
        chk("a5_not_yet", {segment2, segment1}, 8'h00);
        wait_pos(0);
        chk("a5_commit", {segment2, segment1}, 8'hA5);
        chk("a5_ready_back", 8'(rif.valueReady), 8'd1);
        chk("a5_tick", 8'(frameTick), 8'd1);

        // back-to-back bytes: second stalls until the first commits
        send(8'h3C);
        send(8'h7E);
        chk("b2b_first_shown", {segment2, segment1}, 8'h3C);
        chk("b2b_second_pending", 8'(rif.valueReady), 8'd0);
        wait_pos(0);
        chk("b2b_second_commit", {segment2, segment1}, 8'h7E);

        // display disabled for 20 cycles
        rif.displayOn = 1'b0;
        step(2);
        chk("off_blank", 8'(blank), 8'd1);
        step(18);
        rif.displayOn = 1'b1;
        step(2);

        // reset pulse in ON1 with a byte pending
        wait_pos(0);
        send(8'h55);
        wait_pos(7);
        chk("mid_in_on1", 8'(counter), 8'd1);
        reset = 1'b1;
        step(1);
        chk("mid_rst_counter", 8'(counter), 8'd1);
        chk("mid_rst_segments", {segment2, segment1}, 8'h00);
        chk("mid_rst_ready", 8'(rif.valueReady), 8'd1);
        chk("mid_rst_tick", 8'(frameTick), 8'd0);
        reset = 1'b0;
        step(14);
        chk("mid_55_dropped", {segment2, segment1}, 8'h00);

        // valid on the commit edge while a byte is pending
        wait_pos(0);
        send(8'h11);
        wait_pos(11);
        rif.valueValid = 1'b1;
        rif.valueIn    = 8'h22;
        step(1);
        chk("edge_tick", 8'(frameTick), 8'd1);
        chk("edge_commit_old", {segment2, segment1}, 8'h11);
        chk("edge_ready_up", 8'(rif.valueReady), 8'd1);
        step(1);
        chk("edge_new_taken", 8'(rif.valueReady), 8'd0);
        rif.valueValid = 1'b0;
        chk("edge_hold_old", {segment2, segment1}, 8'h11);
        wait_pos(0);
        chk("edge_commit_new", {segment2, segment1}, 8'h22);

        step(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
